// File: rtl/tanh_inverse_sar.sv
// Successive-approximation inverse of a monotone combinational evaluator.
// Finds the smallest x with f(x) >= target by probing the evaluator once per cycle.
module tanh_inverse_sar #(
  parameter int XW = 6,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [YW-1:0] target,
  output logic [XW-1:0] probe_x,
  input  logic [YW-1:0] probe_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic          out_exact,
  output logic          out_sat
);

  localparam int IW = (XW > 1) ? $clog2(XW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHK0,
    SAR,
    FIN,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [YW-1:0] tgt, tgt_n;
  logic [XW-1:0] acc, acc_n;
  logic [IW-1:0] idx, idx_n;
  logic [XW-1:0] x_n;
  logic          ex_n;
  logic          sat_n;
  logic          vld_n;

  logic          hit;
  logic          eq;
  logic [XW-1:0] bit_m;
  logic [XW-1:0] acc_set;
  logic [XW-1:0] acc_upd;
  logic [XW-1:0] acc_inc;

  assign hit     = (probe_y >= tgt);
  assign eq      = (probe_y == tgt);
  assign bit_m   = XW'(1) << idx;
  assign acc_set = acc | bit_m;
  assign acc_inc = acc + XW'(1);
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt       <= '0;
      acc       <= '0;
      idx       <= IW'(XW - 1);
      out_x     <= '0;
      out_exact <= 1'b0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      tgt       <= tgt_n;
      acc       <= acc_n;
      idx       <= idx_n;
      out_x     <= x_n;
      out_exact <= ex_n;
      out_sat   <= sat_n;
      out_valid <= vld_n;
    end
  end

  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    acc_n   = acc;
    idx_n   = idx;
    x_n     = out_x;
    ex_n    = out_exact;
    sat_n   = out_sat;
    vld_n   = out_valid;
    probe_x = '0;
    acc_upd = hit ? acc : acc_set;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          tgt_n   = target;
          acc_n   = '0;
          state_n = CHK0;
        end
      end
      CHK0: begin
        if (hit) begin
          x_n     = '0;
          ex_n    = eq;
          sat_n   = 1'b0;
          state_n = DONE;
        end else begin
          idx_n   = IW'(XW - 1);
          state_n = SAR;
        end
      end
      SAR: begin
        probe_x = acc_set;
        acc_n   = acc_upd;
        if (idx == '0) begin
          // every probe fell short: nothing in range reaches the target
          if (&acc_upd) begin
            x_n     = '1;
            ex_n    = 1'b0;
            sat_n   = 1'b1;
            state_n = DONE;
          end else begin
            state_n = FIN;
          end
        end else begin
          idx_n = idx - IW'(1);
        end
      end
      FIN: begin
        probe_x = acc_inc;
        x_n     = acc_inc;
        ex_n    = eq;
        sat_n   = 1'b0;
        state_n = DONE;
      end
      DONE: begin
        // valid rises one cycle after entry, then holds until taken
        if (out_valid && out_ready) begin
          vld_n   = 1'b0;
          state_n = IDLE;
        end else begin
          vld_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/tanh_inverse_sar.md
Name: tanh_inverse_sar

Overview:
- Sequential inverse evaluator for the generated monotone activation netlists (tanh family, 6-bit input).
- Takes a target output code and drives the combinational evaluator's input through a probe port.
- Binary-searches (successive approximation) for the smallest input x with f(x) >= target.
- Turns the forward netlists into a decoder: output code -> input code.

Parameters:
- XW, 6, width of evaluator input x (probe_x, out_x).
- YW, 8, width of evaluator output y and of target.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- target  in  YW  requested output code, unsigned.
- probe_x  out  XW  input applied to external combinational evaluator.
- probe_y  in  YW  evaluator response to probe_x, same cycle, unsigned; f assumed monotone non-decreasing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_x  out  XW  smallest x with f(x) >= target, or all-ones when saturated.
- out_exact  out  1  f(out_x) == target.
- out_sat  out  1  no x satisfies f(x) >= target.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; in_ready=1; out_valid=0; out_x=0; out_exact=0; out_sat=0; probe_x=0; acc=0; bit index=XW-1.
- Request accept: in_valid & in_ready at edge; target registered as tgt; acc cleared. in_ready=1 only in IDLE.
- Comparisons: unsigned YW-bit; probe_y sampled at each clk edge in CHK0, SAR and FIN.
- probe_x by state: IDLE/DONE = 0; CHK0 = 0; SAR = acc | (1<<i); FIN = acc+1.
- IDLE -> CHK0 on accept.
- CHK0:
  - If probe_y >= tgt: out_x=0, out_exact=(probe_y==tgt), out_sat=0 -> DONE.
  - Else i=XW-1 -> SAR.
- SAR, one bit per cycle, MSB first:
  - If probe_y < tgt, acc |= (1<<i).
  - At i==0 evaluate with the updated acc:
    - acc == all-ones: out_x=all-ones, out_exact=0, out_sat=1 -> DONE.
    - Otherwise -> FIN.
  - Otherwise i decrements.
- FIN: out_x=acc+1, out_exact=(probe_y==tgt), out_sat=0 -> DONE.
- DONE:
  - out_valid=1; out_x/out_exact/out_sat held stable until out_valid & out_ready.
  - Then -> IDLE, out_valid=0. Output regs keep their last values.
- Latency, counted from the accept edge T:
  - Zero result: out_valid high after edge T+2.
  - Normal: after edge T+XW+3 (9 for XW=6).
  - Saturated: after edge T+XW+2.
- Back-to-back: a new request is accepted the cycle after the DONE handshake, never in the same cycle (no bypass).
- target/in_valid changes while busy are ignored. out_ready is ignored outside DONE.
- Reset mid-search or in DONE aborts immediately: all outputs return to reset values next cycle; the pending result is lost.
- Non-monotone f: the block still terminates in a fixed cycle count; the result is unspecified but out_valid protocol holds.

Test Plan:
- Identity evaluator f(x)=x (zero-extended), target=37 -> out_x=37, exact=1, sat=0, out_valid 9 cycles after accept; probe_x sequence 0,32,48,40,36,38,37,37.
- f(x)=2x, target=37 -> out_x=19, exact=0, sat=0.
- f(x)=x+10, target=5 -> zero path: out_x=0, exact=0, out_valid 2 cycles after accept; target=10 -> out_x=0, exact=1.
- f(x)=x, target=200 -> sat=1, out_x=63, exact=0, out_valid 8 cycles after accept. Also target=63 -> out_x=63, exact=1, sat=0.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Then assert out_ready with in_valid high -> new request accepted exactly one cycle later.
- Assert rst_n=0 mid-SAR -> next cycle out_valid=0, in_ready=1, probe_x=0. A fresh request then completes correctly.
